fpu_issue_seq: RTL and testbench

Parametrised issue/completion sequencer for the floating-point unit. Accepts one FP operation per cycle over a valid/ready handshake, tracks every in-flight operation in a latency-indexed completion shift register, and emits an in-order completion pulse carrying the operation's class and tag. Sits between decode/issue and the FPU result mux and writeback stage. It generalises the single-op counter scheme to pipelined multi-op issue with per-class latencies, plus hold and flush control.

---
 rtl/fpu_pkg.sv | 29 ++
 rtl/fpu_issue_seq.sv | 139 +++++++++++++
 tb/tb_fpu_issue_seq.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/fpu_pkg.sv
// fpu_pkg: shared types and defaults for the FPU issue/completion sequencer.
// Holds latency classes, default class latencies, widths and the slot layout.
package fpu_pkg;

    typedef enum logic [1:0] {
        CLS_SHORT = 2'd0,  // cmp / sgnj / cvt.w.s
        CLS_ARITH = 2'd1,  // add / sub / mul / cvt.s.w
        CLS_SQRT  = 2'd2,
        CLS_DIV   = 2'd3
    } fpu_cls_t;

    localparam int FPU_NCLASS  = 4;
    localparam int FPU_CW      = 2;
    localparam int FPU_LAT_W   = 3;
    localparam int FPU_MAX_LAT = 7;
    localparam int FPU_TAG_W   = 5;

    // Class c latency lives at [c*LAT_W +: LAT_W]: SHORT=2 ARITH=3 SQRT=4 DIV=6
    localparam logic [FPU_NCLASS*FPU_LAT_W-1:0] FPU_LAT =
        {3'd6, 3'd4, 3'd3, 3'd2};

    // One completion slot at the default widths
    typedef struct packed {
        logic                 v;
        logic [FPU_CW-1:0]    cls;
        logic [FPU_TAG_W-1:0] tag;
    } pend_t;

endpackage

// File: rtl/fpu_issue_seq.sv
// fpu_issue_seq: in-order FP issue/completion sequencer with per-class latency.
// Ports: clk, rstn (sync, active-low); issue_valid/issue_ready/issue_cls/
// issue_tag handshake; hold, flush; done_valid/done_cls/done_tag completion
// pulse; busy; inflight count of accepted, not yet completed ops.
module fpu_issue_seq
    import fpu_pkg::*;
#(
    parameter int                        NCLASS  = FPU_NCLASS,
    parameter int                        LAT_W   = FPU_LAT_W,
    parameter logic [NCLASS*LAT_W-1:0]   LAT     = FPU_LAT,
    parameter int                        MAX_LAT = FPU_MAX_LAT,
    parameter int                        TAG_W   = FPU_TAG_W,
    localparam int                       CW      = (NCLASS > 1) ? $clog2(NCLASS) : 1,
    localparam int                       IW      = $clog2(MAX_LAT + 2)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             issue_valid,
    output logic             issue_ready,
    input  logic [CW-1:0]    issue_cls,
    input  logic [TAG_W-1:0] issue_tag,
    input  logic             hold,
    input  logic             flush,
    output logic             done_valid,
    output logic [CW-1:0]    done_cls,
    output logic [TAG_W-1:0] done_tag,
    output logic             busy,
    output logic [IW-1:0]    inflight
);

    typedef struct packed {
        logic             v;
        logic [CW-1:0]    cls;
        logic [TAG_W-1:0] tag;
    } slot_t;

    // pend_q[k] completes k cycles from now (absent hold)
    slot_t [MAX_LAT:1] pend_q;
    slot_t [MAX_LAT:1] pend_d;

    logic [LAT_W-1:0] iss_lat;
    logic             lat_ok;
    logic             blocked;
    logic             accept;
    logic             acc_direct;
    logic             done_v_d;
    logic             any_pend;

    for (genvar c = 0; c < NCLASS; c++) begin : g_chk
        if (int'(LAT[c*LAT_W +: LAT_W]) < 1 ||
            int'(LAT[c*LAT_W +: LAT_W]) > MAX_LAT) begin : g_bad
            $error("fpu_issue_seq: class latency outside 1..MAX_LAT");
        end
    end

    always_comb begin
        iss_lat = '0;
        for (int c = 0; c < NCLASS; c++) begin
            if (int'(issue_cls) == c) iss_lat = LAT[c*LAT_W +: LAT_W];
        end
    end

    // Only an illegal class maps to latency 0; refuse it rather than
    // corrupt the in-flight count.
    assign lat_ok = (iss_lat != '0);

    // Any op due at or after the new op's slot would collide or
    // complete out of order.
    always_comb begin
        blocked = 1'b0;
        for (int k = 1; k <= MAX_LAT; k++) begin
            if (pend_q[k].v && (k >= int'(iss_lat))) blocked = 1'b1;
        end
    end

    assign issue_ready = ~hold & ~flush & lat_ok & ~blocked;
    assign accept      = issue_valid & issue_ready;
    assign acc_direct  = accept & (iss_lat == LAT_W'(1));
    assign done_v_d    = acc_direct | pend_q[1].v;

    for (genvar k = 1; k <= MAX_LAT; k++) begin : g_slot
        slot_t shift_in;
        if (k == MAX_LAT) begin : g_top
            assign shift_in = '0;
        end else begin : g_mid
            assign shift_in = pend_q[k+1];
        end
        // Target slot is empty after the shift, so the write can win.
        assign pend_d[k] = (accept && (int'(iss_lat) == k + 1))
                         ? {1'b1, issue_cls, issue_tag}
                         : shift_in;
    end

    always_comb begin
        any_pend = 1'b0;
        for (int k = 1; k <= MAX_LAT; k++) begin
            any_pend = any_pend | pend_q[k].v;
        end
    end

    assign busy = any_pend | done_valid;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            pend_q     <= '0;
            done_valid <= 1'b0;
            done_cls   <= '0;
            done_tag   <= '0;
            inflight   <= '0;
        end else if (flush) begin
            for (int k = 1; k <= MAX_LAT; k++) pend_q[k].v <= 1'b0;
            done_valid <= 1'b0;
            inflight   <= '0;
        end else if (hold) begin
            done_valid <= 1'b0;
        end else begin
            pend_q     <= pend_d;
            done_valid <= done_v_d;
            if (acc_direct) begin
                done_cls <= issue_cls;
                done_tag <= issue_tag;
            end else begin
                done_cls <= pend_q[1].cls;
                done_tag <= pend_q[1].tag;
            end
            inflight <= inflight + IW'(accept) - IW'(done_v_d);
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (rstn && issue_valid && !hold && !flush) begin
            assert (int'(issue_cls) < NCLASS)
            else $error("fpu_issue_seq: illegal issue_cls %0d", issue_cls);
        end
    end
`endif

endmodule

// File: tb/tb_fpu_issue_seq.sv
// tb_fpu_issue_seq: directed and random checks of fpu_issue_seq against a
// countdown-list reference model of in-flight operations.
module tb_fpu_issue_seq;
    import fpu_pkg::*;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       issue_valid = 1'b0;
    logic       issue_ready;
    logic [1:0] issue_cls = '0;
    logic [4:0] issue_tag = '0;
    logic       hold = 1'b0;
    logic       flush = 1'b0;
    logic       done_valid;
    logic [1:0] done_cls;
    logic [4:0] done_tag;
    logic       busy;
    logic [3:0] inflight;

    fpu_issue_seq dut (
        .clk         (clk),
        .rstn        (rstn),
        .issue_valid (issue_valid),
        .issue_ready (issue_ready),
        .issue_cls   (issue_cls),
        .issue_tag   (issue_tag),
        .hold        (hold),
        .flush       (flush),
        .done_valid  (done_valid),
        .done_cls    (done_cls),
        .done_tag    (done_tag),
        .busy        (busy),
        .inflight    (inflight)
    );

    always #5 clk = ~clk;

    typedef struct {
        int cls;
        int tag;
        int rem;
    } op_t;

    op_t q[$];
    int  e_dv, e_dc, e_dt;
    bit  e_dct;
    int  nchk = 0;
    int  npass = 0;
    int  cyc = 0;
    int  rdy_cyc = -1;
    int  base;
    int  log_cyc[$];
    int  log_tag[$];
    int  log_cls[$];

    function automatic int lat_of(int c);
        case (c)
            0:       return 2;
            1:       return 3;
            2:       return 4;
            default: return 6;
        endcase
    endfunction

    // Ready when nothing in flight would finish at or after the new op.
    function automatic bit m_ready(int c, bit h, bit f);
        if (h || f) return 1'b0;
        foreach (q[i]) if (q[i].rem >= lat_of(c)) return 1'b0;
        return 1'b1;
    endfunction

    task automatic chk(input string nm, input logic [31:0] obs,
                       input logic [31:0] exp);
        nchk++;
        assert (obs === exp) npass++;
        else $error("FAIL %s: observed %0d expected %0d", nm, obs, exp);
    endtask

    task automatic clr_log();
        log_cyc.delete();
        log_tag.delete();
        log_cls.delete();
    endtask

    task automatic step(input bit r, input bit v, input int c, input int t,
                        input bit h, input bit f);
        bit  er, acc;
        op_t nq[$];
        op_t o;
        rstn        = r;
        issue_valid = v;
        issue_cls   = c[1:0];
        issue_tag   = t[4:0];
        hold        = h;
        flush       = f;
        #1;
        er = m_ready(c, h, f);
        if (r) chk("issue_ready", issue_ready, er);
        if (issue_ready && v) rdy_cyc = cyc;
        acc = r && v && er;
        @(posedge clk);
        cyc++;
        if (!r) begin
            q.delete();
            e_dv = 0; e_dc = 0; e_dt = 0; e_dct = 1'b1;
        end else if (f) begin
            q.delete();
            e_dv = 0; e_dct = 1'b0;
        end else if (h) begin
            e_dv = 0;
        end else begin
            e_dv = 0;
            foreach (q[i]) begin
                o = q[i];
                o.rem--;
                if (o.rem == 0) begin
                    e_dv = 1; e_dc = o.cls; e_dt = o.tag;
                end else begin
                    nq.push_back(o);
                end
            end
            if (acc) begin
                o.cls = c; o.tag = t; o.rem = lat_of(c) - 1;
                nq.push_back(o);
            end
            q = nq;
            e_dct = (e_dv != 0);
        end
        @(negedge clk);
        chk("done_valid", done_valid, e_dv);
        if (e_dct) begin
            chk("done_cls", done_cls, e_dc);
            chk("done_tag", done_tag, e_dt);
        end
        chk("inflight", inflight, q.size());
        chk("busy", busy, (q.size() > 0 || e_dv != 0) ? 1 : 0);
        if (done_valid === 1'b1) begin
            log_cyc.push_back(cyc);
            log_tag.push_back(int'(done_tag));
            log_cls.push_back(int'(done_cls));
        end
    endtask

    task automatic idle(input int n);
        repeat (n) step(1, 0, 0, 0, 0, 0);
    endtask

    initial begin
        int exp_rel[4];
        @(negedge clk);

        // Single ARITH op issued in cycle 10 after reset
        step(0, 0, 0, 0, 0, 0);
        clr_log();
        base = cyc;
        idle(10);
        step(1, 1, CLS_ARITH, 5, 0, 0);
        chk("s1_inflight_1", inflight, 1);
        idle(5);
        chk("s1_pulses", log_cyc.size(), 1);
        if (log_cyc.size() > 0) begin
            chk("s1_done_cycle", log_cyc[0] - base, 13);
            chk("s1_done_tag", log_tag[0], 5);
            chk("s1_done_cls", log_cls[0], 1);
        end
        chk("s1_inflight_0", inflight, 0);

        // Back-to-back ops of every class
        clr_log();
        base = cyc;
        step(1, 1, CLS_SHORT, 1, 0, 0);
        step(1, 1, CLS_ARITH, 2, 0, 0);
        step(1, 1, CLS_SQRT,  3, 0, 0);
        step(1, 1, CLS_DIV,   4, 0, 0);
        idle(8);
        exp_rel = '{2, 4, 6, 9};
        chk("s2_pulses", log_cyc.size(), 4);
        for (int i = 0; i < 4 && i < log_cyc.size(); i++) begin
            chk("s2_done_cycle", log_cyc[i] - base, exp_rel[i]);
            chk("s2_done_tag", log_tag[i], i + 1);
        end

        // SHORT behind DIV waits for the DIV slot to drop below 2
        clr_log();
        base = cyc;
        step(1, 1, CLS_DIV, 7, 0, 0);
        rdy_cyc = -1;
        for (int i = 0; i < 10; i++) begin
            step(1, 1, CLS_SHORT, 8, 0, 0);
            if (rdy_cyc >= 0) break;
        end
        chk("s3_accept_cycle", rdy_cyc - base, 5);
        idle(4);
        chk("s3_pulses", log_cyc.size(), 2);
        if (log_cyc.size() == 2) begin
            chk("s3_div_cycle", log_cyc[0] - base, 6);
            chk("s3_div_tag", log_tag[0], 7);
            chk("s3_short_cycle", log_cyc[1] - base, 7);
            chk("s3_short_tag", log_tag[1], 8);
        end

        // Two hold cycles stretch ARITH latency by two
        clr_log();
        base = cyc;
        step(1, 1, CLS_ARITH, 9, 0, 0);
        step(1, 1, CLS_SHORT, 0, 1, 0);
        step(1, 1, CLS_SHORT, 0, 1, 0);
        idle(5);
        chk("s4_pulses", log_cyc.size(), 1);
        if (log_cyc.size() > 0) begin
            chk("s4_done_cycle", log_cyc[0] - base, 5);
            chk("s4_done_tag", log_tag[0], 9);
        end

        // Flush with three ops in flight
        clr_log();
        step(1, 1, CLS_SQRT, 10, 0, 0);
        step(1, 1, CLS_DIV,  11, 0, 0);
        step(1, 1, CLS_DIV,  12, 0, 0);
        chk("s5_inflight_3", inflight, 3);
        step(1, 1, CLS_SHORT, 13, 0, 1);
        chk("s5_inflight_0", inflight, 0);
        chk("s5_busy_0", busy, 0);
        base = cyc;
        rdy_cyc = -1;
        step(1, 1, CLS_SHORT, 14, 0, 0);
        chk("s5_accept_cycle", rdy_cyc, base);
        idle(10);
        chk("s5_pulses", log_cyc.size(), 1);
        if (log_cyc.size() > 0) chk("s5_done_tag", log_tag[0], 14);

        // Reset with a DIV pending
        clr_log();
        step(1, 1, CLS_DIV, 15, 0, 0);
        idle(1);
        step(0, 0, 0, 0, 0, 0);
        chk("s6_done_valid", done_valid, 0);
        chk("s6_done_cls", done_cls, 0);
        chk("s6_done_tag", done_tag, 0);
        chk("s6_inflight", inflight, 0);
        chk("s6_busy", busy, 0);
        idle(8);
        chk("s6_pulses", log_cyc.size(), 0);

        // Random traffic
        for (int i = 0; i < 800; i++) begin
            bit rb, vb, hb, fb;
            int c, t;
            rb = ($urandom_range(199) != 0);
            vb = ($urandom_range(9) < 7);
            hb = ($urandom_range(9) == 0);
            fb = ($urandom_range(39) == 0);
            c  = $urandom_range(3);
            t  = $urandom_range(31);
            step(rb, vb, c, t, hb, fb);
        end
        idle(10);

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule
